// File: rtl/sprite_pkg.sv
// sprite_pkg: shared screen constants, coordinate types and sizing helpers for the sprite
// blitter slice.
//
// Contents:
//   SCREEN_W / SCREEN_H  visible raster size (640x480)
//   coord_t              10-bit screen coordinate
//   coord_ext_t          11-bit coordinate, used for edge sums so they clip instead of wrapping
//   cnt_width()          bit width of a counter holding 0..n-1 (never less than 1)
//
// Palette indices are parameterised per instance, so each module declares
//   typedef logic [IDX_W-1:0] pix_idx_t;
// locally rather than sharing a fixed-width type from this package.
package sprite_pkg;

   localparam int unsigned SCREEN_W = 640;
   localparam int unsigned SCREEN_H = 480;
   localparam int unsigned COORD_W  = 10;

   typedef logic [COORD_W-1:0] coord_t;
   typedef logic [COORD_W:0]   coord_ext_t;

   function automatic int unsigned cnt_width(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/sprite_anim_ctrl.sv
// sprite_anim_ctrl: animation frame sequencer for the sprite blitter.
//
// A tick counter advances on every frame_start while anim_en is high. When it reaches
// ANIM_DIV-1 it wraps to 0 and cur_frame steps to the next frame, wrapping FRAMES-1 -> 0.
// anim_restart clears both the counter and the frame, and wins over a same-cycle frame_start.
// With anim_en low, both the counter and the frame hold.
//
// Ports:
//   vga_clk       in   pixel clock
//   reset_n       in   asynchronous active-low reset
//   frame_start   in   one-cycle pulse at the start of vertical blank
//   anim_en       in   advance the animation on frame_start
//   anim_restart  in   return to frame 0 and clear the tick counter
//   cur_frame     out  current animation frame
module sprite_anim_ctrl
   import sprite_pkg::*;
#(
   parameter int unsigned FRAMES   = 4,
   parameter int unsigned ANIM_DIV = 8,
   localparam int unsigned FRAME_W = cnt_width(FRAMES),
   localparam int unsigned TICK_W  = cnt_width(ANIM_DIV)
) (
   input  logic               vga_clk,
   input  logic               reset_n,
   input  logic               frame_start,
   input  logic               anim_en,
   input  logic               anim_restart,
   output logic [FRAME_W-1:0] cur_frame
);

   localparam logic [TICK_W-1:0]  TICK_LAST  = TICK_W'(ANIM_DIV - 1);
   localparam logic [FRAME_W-1:0] FRAME_LAST = FRAME_W'(FRAMES - 1);

   logic [TICK_W-1:0]  tick_q, tick_d;
   logic [FRAME_W-1:0] frame_q, frame_d;

   always_comb begin
      tick_d  = tick_q;
      frame_d = frame_q;
      if (anim_restart) begin
         tick_d  = '0;
         frame_d = '0;
      end else if (frame_start && anim_en) begin
         if (tick_q == TICK_LAST) begin
            tick_d  = '0;
            frame_d = (frame_q == FRAME_LAST) ? '0 : frame_q + 1'b1;
         end else begin
            tick_d = tick_q + 1'b1;
         end
      end
   end

   always_ff @(posedge vga_clk or negedge reset_n) begin
      if (!reset_n) begin
         tick_q  <= '0;
         frame_q <= '0;
      end else begin
         tick_q  <= tick_d;
         frame_q <= frame_d;
      end
   end

   assign cur_frame = frame_q;

endmodule

// File: rtl/sprite_blitter.sv
// sprite_blitter: draws one multi-frame sprite at native size at a programmable position on a
// 640x480 raster. Looks up an external synchronous sprite ROM and hands a palette index plus a
// hit flag to the compositor.
//
// Pipeline (3 vga_clk from DrawX/DrawY to pix_valid/pix_idx):
//   stage 0  combinational hit test and local coordinates
//   stage 1  registered ROM address (0 when not hit), hit/blank delayed
//   stage 2  ROM returns rom_q, hit/blank delayed again
//   stage 3  registered pix_valid/pix_idx, transparent index suppressed
//
// Position (and flip, when mirroring is built in) is taken from pos_x/pos_y/flip only on
// frame_start so the sprite never tears mid-frame.
//
// Build option: define SPRITE_BLITTER_MIRROR_EN to honour flip (horizontal mirror). Without it
// the flip port is accepted but ignored.
//
// Ports:
//   vga_clk       in   pixel clock
//   reset_n       in   asynchronous active-low reset
//   DrawX, DrawY  in   current pixel column/row
//   blank         in   1 = active video
//   frame_start   in   one-cycle pulse at start of vertical blank
//   pos_x, pos_y  in   requested sprite left/top edge
//   anim_en       in   advance animation on frame_start
//   anim_restart  in   return to frame 0
//   flip          in   horizontal mirror request
//   rom_addr      out  registered sprite ROM address
//   rom_q         in   ROM data, valid one vga_clk after rom_addr
//   pix_valid     out  opaque sprite pixel at this position
//   pix_idx       out  palette index, 0 when pix_valid=0
//   cur_frame     out  current animation frame
module sprite_blitter
   import sprite_pkg::*;
#(
   parameter int unsigned SPRITE_W        = 20,
   parameter int unsigned SPRITE_H        = 40,
   parameter int unsigned FRAMES          = 4,
   parameter int unsigned IDX_W           = 4,
   parameter int unsigned TRANSPARENT_IDX = 0,
   parameter int unsigned ANIM_DIV        = 8,
   localparam int unsigned ADDR_W  = $clog2(SPRITE_W * SPRITE_H * FRAMES),
   localparam int unsigned FRAME_W = cnt_width(FRAMES)
) (
   input  logic               vga_clk,
   input  logic               reset_n,
   input  logic [9:0]         DrawX,
   input  logic [9:0]         DrawY,
   input  logic               blank,
   input  logic               frame_start,
   input  logic [9:0]         pos_x,
   input  logic [9:0]         pos_y,
   input  logic               anim_en,
   input  logic               anim_restart,
   input  logic               flip,
   output logic [ADDR_W-1:0]  rom_addr,
   input  logic [IDX_W-1:0]   rom_q,
   output logic               pix_valid,
   output logic [IDX_W-1:0]   pix_idx,
   output logic [FRAME_W-1:0] cur_frame
);

   typedef logic [IDX_W-1:0] pix_idx_t;

   localparam int unsigned FRAME_PIX = SPRITE_W * SPRITE_H;
   localparam pix_idx_t    TRANSP    = pix_idx_t'(TRANSPARENT_IDX);

   // ------------------------------------------------------------------------------------------
   // Animation sequencer
   // ------------------------------------------------------------------------------------------
   sprite_anim_ctrl #(
      .FRAMES   (FRAMES),
      .ANIM_DIV (ANIM_DIV)
   ) u_anim_ctrl (
      .vga_clk      (vga_clk),
      .reset_n      (reset_n),
      .frame_start  (frame_start),
      .anim_en      (anim_en),
      .anim_restart (anim_restart),
      .cur_frame    (cur_frame)
   );

   // ------------------------------------------------------------------------------------------
   // Shadow latch: active position only changes on frame_start
   // ------------------------------------------------------------------------------------------
   coord_t ax_q, ay_q;

   always_ff @(posedge vga_clk or negedge reset_n) begin
      if (!reset_n) begin
         ax_q <= '0;
         ay_q <= '0;
      end else if (frame_start) begin
         ax_q <= pos_x;
         ay_q <= pos_y;
      end
   end

`ifdef SPRITE_BLITTER_MIRROR_EN
   logic flip_a_q;

   always_ff @(posedge vga_clk or negedge reset_n) begin
      if (!reset_n) begin
         flip_a_q <= 1'b0;
      end else if (frame_start) begin
         flip_a_q <= flip;
      end
   end
`else
   logic unused_flip;
   assign unused_flip = flip;
`endif

   // ------------------------------------------------------------------------------------------
   // Stage 0: hit test and local coordinates
   // ------------------------------------------------------------------------------------------
   coord_ext_t x_end, y_end;
   logic       hit;
   coord_t     lx, ly, col;

   // 11-bit edge sums: a sprite overhanging the right/bottom edge clips rather than wrapping
   // back into column/row 0.
   assign x_end = {1'b0, ax_q} + coord_ext_t'(SPRITE_W - 1);
   assign y_end = {1'b0, ay_q} + coord_ext_t'(SPRITE_H - 1);

   assign hit = (DrawX >= ax_q) && ({1'b0, DrawX} <= x_end) &&
                (DrawY >= ay_q) && ({1'b0, DrawY} <= y_end);

   assign lx = DrawX - ax_q;
   assign ly = DrawY - ay_q;

`ifdef SPRITE_BLITTER_MIRROR_EN
   assign col = flip_a_q ? (coord_t'(SPRITE_W - 1) - lx) : lx;
`else
   assign col = lx;
`endif

   // ------------------------------------------------------------------------------------------
   // Stage 1: ROM address (frames stored back to back, row-major inside a frame)
   // ------------------------------------------------------------------------------------------
   logic [ADDR_W-1:0] addr_calc, addr_d, addr_q;

   assign addr_calc = ADDR_W'(32'(cur_frame) * FRAME_PIX + 32'(ly) * SPRITE_W + 32'(col));

   always_comb begin
      addr_d = '0;
      if (hit) begin
         addr_d = addr_calc;
      end
   end

   logic hit_s1_q, blank_s1_q;
   logic hit_s2_q, blank_s2_q;

   // ------------------------------------------------------------------------------------------
   // Stage 3: output qualification
   // ------------------------------------------------------------------------------------------
   logic     pix_valid_d, pix_valid_q;
   pix_idx_t pix_idx_d, pix_idx_q;

   always_comb begin
      pix_valid_d = hit_s2_q && blank_s2_q && (rom_q != TRANSP);
      pix_idx_d   = '0;
      if (pix_valid_d) begin
         pix_idx_d = rom_q;
      end
   end

   always_ff @(posedge vga_clk or negedge reset_n) begin
      if (!reset_n) begin
         addr_q      <= '0;
         hit_s1_q    <= 1'b0;
         blank_s1_q  <= 1'b0;
         hit_s2_q    <= 1'b0;
         blank_s2_q  <= 1'b0;
         pix_valid_q <= 1'b0;
         pix_idx_q   <= '0;
      end else begin
         addr_q      <= addr_d;
         hit_s1_q    <= hit;
         blank_s1_q  <= blank;
         hit_s2_q    <= hit_s1_q;
         blank_s2_q  <= blank_s1_q;
         pix_valid_q <= pix_valid_d;
         pix_idx_q   <= pix_idx_d;
      end
   end

   assign rom_addr  = addr_q;
   assign pix_valid = pix_valid_q;
   assign pix_idx   = pix_idx_q;

endmodule

// File: doc/sprite_blitter.md
Name: sprite_blitter

Overview:
- Parametrised successor to the stretch-to-screen sprite demo.
- Draws one multi-frame sprite at native size at a programmable screen position (640x480 VGA timing).
- Supports frame-based animation, palette-index transparency and tear-free position update at frame start.
- Drives an external synchronous sprite ROM; emits a palette index plus hit flag to the compositor/palette stage.

Parameters:
- SPRITE_W, 20: sprite width in pixels.
- SPRITE_H, 40: sprite height in pixels.
- FRAMES, 4: animation frames stored back-to-back in ROM.
- IDX_W, 4: palette index width.
- TRANSPARENT_IDX, 0: palette index treated as see-through.
- ANIM_DIV, 8: frame_start pulses per animation step (>=1).
- ADDR_W, $clog2(SPRITE_W*SPRITE_H*FRAMES): ROM address width (derived, not overridden).

Ports:
- vga_clk  in  1  pixel clock.
- reset_n  in  1  asynchronous, active-low reset.
- DrawX  in  10  current pixel column.
- DrawY  in  10  current pixel row.
- blank  in  1  1 = active video.
- frame_start  in  1  one-cycle pulse at start of vertical blank.
- pos_x  in  10  requested sprite left edge.
- pos_y  in  10  requested sprite top edge.
- anim_en  in  1  advance animation on frame_start.
- anim_restart  in  1  return to frame 0.
- flip  in  1  horizontal mirror request (only with feature).
- rom_addr  out  ADDR_W  registered ROM address.
- rom_q  in  IDX_W  ROM data, valid one vga_clk after rom_addr.
- pix_valid  out  1  opaque sprite pixel at this position.
- pix_idx  out  IDX_W  palette index; 0 when pix_valid=0.
- cur_frame  out  $clog2(FRAMES)  current animation frame.

Behaviour:
- Reset (async, reset_n=0): active position 0/0, flip_a 0, tick counter 0, cur_frame 0, rom_addr 0, all pipeline flags 0, pix_valid 0, pix_idx 0. Outputs clear immediately, not at the next edge.
- Shadow latch:
  - On frame_start, pos_x/pos_y/flip are copied to active registers ax/ay/flip_a.
  - Mid-frame changes on the inputs are ignored until the next frame_start.
- Animation:
  - On frame_start with anim_en=1, tick counter increments.
  - At ANIM_DIV-1 the counter wraps to 0 and cur_frame increments modulo FRAMES (FRAMES-1 -> 0).
  - anim_restart=1 forces counter=0 and cur_frame=0 and wins over a same-cycle frame_start.
  - anim_en=0 holds both counter and cur_frame.
- Hit test (stage 0, combinational):
  - hit = DrawX>=ax && DrawX<=ax+SPRITE_W-1 && DrawY>=ay && DrawY<=ay+SPRITE_H-1.
  - Sums are computed at 11 bits so a sprite overhanging x=639 or y=479 clips and never wraps to column 0.
  - lx = DrawX-ax, ly = DrawY-ay.
- Address (stage 1, registered):
  - rom_addr = cur_frame*SPRITE_W*SPRITE_H + ly*SPRITE_W + lx, using constant multiplies only (no dividers).
  - rom_addr is held at 0 when not hit.
  - hit and blank are delayed alongside rom_addr.
- Stage 2: ROM returns rom_q; hit and blank are delayed one more cycle.
- Stage 3 (registered output):
  - pix_valid = hit_d & blank_d & (rom_q != TRANSPARENT_IDX).
  - pix_idx = pix_valid ? rom_q : 0.
- Latency is exactly 3 vga_clk from DrawX/DrawY to pix_valid/pix_idx. The downstream compositor delays its background path by 3 to match.
- frame_start coinciding with an active pixel: the new position applies from the following cycle. In practice this never happens because frame_start occurs in blanking.

Optional Feature:
- Macro SPRITE_BLITTER_MIRROR_EN.
- Defined: when flip_a=1, the column used in the address is SPRITE_W-1-lx. flip is latched with position on frame_start.
- Undefined: the flip port exists but is ignored, flip_a is not implemented, and the column is always lx.

Decomposition:
- Package sprite_pkg holds:
  - SCREEN_W=640 and SCREEN_H=480.
  - typedef coord_t as logic [9:0].
  - parameterised palette-index typedef convention (pix_idx_t).
- One sub-module, sprite_anim_ctrl, contains the tick counter, cur_frame and restart/enable priority. The blitter top keeps the shadow latch, hit test and pipeline.

Test Plan:
- Position/latency: pos=(100,50), frame_start, defaults, ROM holds idx 5 everywhere. At DrawX=100, DrawY=50 the bench sees pix_valid=1, pix_idx=5 three cycles later. DrawX=99 and DrawX=120 give pix_valid=0.
- Address map: cur_frame=2, pixel (103,52). rom_addr = 2*800 + 2*20 + 3 = 1643 one cycle after the drive.
- Transparency/blank: ROM returns 0 inside the sprite -> pix_valid=0, pix_idx=0. ROM returns 7 with blank=0 -> pix_valid=0.
- Animation:
  - anim_en=1, ANIM_DIV=8: cur_frame steps 0->1 after the 8th frame_start and wraps 3->0 after 32 pulses.
  - anim_restart together with frame_start -> cur_frame=0, counter=0.
  - anim_en=0 -> frame holds.
- Edge clip and shadow:
  - pos_x=630 gives hits only for DrawX 630..639 and none at DrawX 0..9.
  - Changing pos_x mid-frame has no effect until the next frame_start.
- Reset mid-line and mirror:
  - reset_n low while pix_valid=1 drops all outputs asynchronously.
  - With SPRITE_BLITTER_MIRROR_EN defined and flip=1, pixel lx=0 reads column 19.
